// File: rtl/feed_arbiter.sv
// feed_arbiter
// Packet-level round-robin arbiter that shares the parser's single input bus
// (InBus_*) between two upstream feed sources, A and B.
//   - A grant is held for a whole packet (first word through LastWord).
//   - Packets longer than MAX_WORDS are cut: word MAX_WORDS goes out with
//     InBus_LastWord forced high and the rest of the packet is acked and
//     dropped (FLUSH).
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   A_* / B_*               source valid/last/data/mod in, DataAck out
//   InBus_*                 bus to parser, InBus_DataAck in from parser
//   Grant                   registered one-hot owner (01 A, 10 B, 00 none)
//   PktCount_A/B            saturating completed-packet counters
//   Trunc_Err               one-cycle pulse the cycle after a truncating word
module feed_arbiter #(
  parameter int DATA_W    = 64,
  parameter int MOD_W     = 3,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              A_DataValid,
  input  logic              A_LastWord,
  input  logic [DATA_W-1:0] A_Data,
  input  logic [MOD_W-1:0]  A_DataMod,
  output logic              A_DataAck,
  input  logic              B_DataValid,
  input  logic              B_LastWord,
  input  logic [DATA_W-1:0] B_Data,
  input  logic [MOD_W-1:0]  B_DataMod,
  output logic              B_DataAck,
  output logic              InBus_DataValid,
  output logic              InBus_LastWord,
  output logic [DATA_W-1:0] InBus_Data,
  output logic [MOD_W-1:0]  InBus_DataMod,
  input  logic              InBus_DataAck,
  output logic [1:0]        Grant,
  output logic [CNT_W-1:0]  PktCount_A,
  output logic [CNT_W-1:0]  PktCount_B,
  output logic              Trunc_Err
);

  localparam int WC_W = $clog2(MAX_WORDS + 1);
  // Word counter value while the MAX_WORDS-th word is on the bus.
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(MAX_WORDS - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, FLUSH} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;       // 0 = A, 1 = B
  logic              last_b_q, last_b_d;     // last served source was B
  logic [1:0]        grant_q, grant_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  pkt_a_q, pkt_a_d;
  logic [CNT_W-1:0]  pkt_b_q, pkt_b_d;
  logic              trunc_q, trunc_d;

  // Current owner's signals.
  logic              src_valid;
  logic              src_last;
  logic [DATA_W-1:0] src_data;
  logic [MOD_W-1:0]  src_mod;
  logic              at_max;

  assign src_valid = owner_q ? B_DataValid : A_DataValid;
  assign src_last  = owner_q ? B_LastWord  : A_LastWord;
  assign src_data  = owner_q ? B_Data      : A_Data;
  assign src_mod   = owner_q ? B_DataMod   : A_DataMod;
  assign at_max    = (wcnt_q == LAST_IDX);

  // Bus and ack steering. The parser ack only reaches the source acks,
  // never the InBus_* outputs.
  always_comb begin
    InBus_DataValid = 1'b0;
    InBus_LastWord  = 1'b0;
    InBus_Data      = '0;
    InBus_DataMod   = '0;
    A_DataAck       = 1'b0;
    B_DataAck       = 1'b0;
    case (state_q)
      GNT_A, GNT_B: begin
        InBus_DataValid = src_valid;
        InBus_LastWord  = src_last | at_max;
        InBus_Data      = src_data;
        InBus_DataMod   = src_mod;
        if (owner_q) B_DataAck = InBus_DataAck;
        else         A_DataAck = InBus_DataAck;
      end
      FLUSH: begin
        // Drain the rest of a truncated packet; nothing reaches the parser.
        if (owner_q) B_DataAck = 1'b1;
        else         A_DataAck = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_b_d = last_b_q;
    grant_d  = grant_q;
    wcnt_d   = wcnt_q;
    pkt_a_d  = pkt_a_q;
    pkt_b_d  = pkt_b_q;
    trunc_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (A_DataValid && (!B_DataValid || last_b_q)) begin
          state_d = GNT_A;
          owner_d = 1'b0;
          grant_d = 2'b01;
        end else if (B_DataValid) begin
          state_d = GNT_B;
          owner_d = 1'b1;
          grant_d = 2'b10;
        end
      end
      GNT_A, GNT_B: begin
        if (src_valid && InBus_DataAck) begin
          if (src_last || at_max) begin
            // Packet completes toward the parser, whole or truncated.
            if (owner_q) pkt_b_d = (pkt_b_q == '1) ? pkt_b_q : pkt_b_q + 1'b1;
            else         pkt_a_d = (pkt_a_q == '1) ? pkt_a_q : pkt_a_q + 1'b1;
            wcnt_d = '0;
            if (src_last) begin
              last_b_d = owner_q;
              grant_d  = 2'b00;
              state_d  = IDLE;
            end else begin
              trunc_d = 1'b1;
              state_d = FLUSH;
            end
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (src_valid && src_last) begin
          last_b_d = owner_q;
          grant_d  = 2'b00;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_b_q <= 1'b1;   // A wins the first tie
      grant_q  <= 2'b00;
      wcnt_q   <= '0;
      pkt_a_q  <= '0;
      pkt_b_q  <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_b_q <= last_b_d;
      grant_q  <= grant_d;
      wcnt_q   <= wcnt_d;
      pkt_a_q  <= pkt_a_d;
      pkt_b_q  <= pkt_b_d;
      trunc_q  <= trunc_d;
    end
  end

  assign Grant      = grant_q;
  assign PktCount_A = pkt_a_q;
  assign PktCount_B = pkt_b_q;
  assign Trunc_Err  = trunc_q;

endmodule

// File: tb/tb_feed_arbiter.sv
// tb_feed_arbiter
// Directed bench for feed_arbiter, built with MAX_WORDS = 4 and CNT_W = 2 so
// truncation and counter saturation are reachable with short packets.
module tb_feed_arbiter;

  localparam logic [63:0] A1 = 64'h0004415500204401;
  localparam logic [63:0] A2 = 64'hDEADBEEF00000000;
  localparam logic [63:0] B1 = 64'h0014421122334455;
  localparam logic [63:0] B2 = 64'hEEFFEEDD00044101;
  localparam logic [63:0] WBASE = 64'h1000000000000000;

  logic        clk;
  logic        reset;
  logic        A_DataValid, A_LastWord, A_DataAck;
  logic [63:0] A_Data;
  logic [2:0]  A_DataMod;
  logic        B_DataValid, B_LastWord, B_DataAck;
  logic [63:0] B_Data;
  logic [2:0]  B_DataMod;
  logic        InBus_DataValid, InBus_LastWord, InBus_DataAck;
  logic [63:0] InBus_Data;
  logic [2:0]  InBus_DataMod;
  logic [1:0]  Grant;
  logic [1:0]  PktCount_A, PktCount_B;
  logic        Trunc_Err;

  int n_tests = 0;
  int n_fail  = 0;

  feed_arbiter #(.DATA_W(64), .MOD_W(3), .MAX_WORDS(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .A_DataValid(A_DataValid), .A_LastWord(A_LastWord), .A_Data(A_Data),
    .A_DataMod(A_DataMod), .A_DataAck(A_DataAck),
    .B_DataValid(B_DataValid), .B_LastWord(B_LastWord), .B_Data(B_Data),
    .B_DataMod(B_DataMod), .B_DataAck(B_DataAck),
    .InBus_DataValid(InBus_DataValid), .InBus_LastWord(InBus_LastWord),
    .InBus_Data(InBus_Data), .InBus_DataMod(InBus_DataMod),
    .InBus_DataAck(InBus_DataAck),
    .Grant(Grant), .PktCount_A(PktCount_A), .PktCount_B(PktCount_B),
    .Trunc_Err(Trunc_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    A_DataValid = 1'b0; A_LastWord = 1'b0; A_Data = '0; A_DataMod = '0;
    B_DataValid = 1'b0; B_LastWord = 1'b0; B_Data = '0; B_DataMod = '0;
    InBus_DataAck = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset;
    idle_inputs();
    A_DataValid = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if (Grant !== 2'b00 || InBus_DataValid !== 1'b0 || A_DataAck !== 1'b0 ||
        B_DataAck !== 1'b0 || PktCount_A !== 2'd0 || PktCount_B !== 2'd0 ||
        Trunc_Err !== 1'b0 || InBus_Data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state: got grant=%b vld=%b acks=%b%b cnt=%0d/%0d trunc=%b expected all zero",
               Grant, InBus_DataValid, A_DataAck, B_DataAck, PktCount_A, PktCount_B, Trunc_Err);
    end
    cyc();
    cyc();
    n_tests++;
    if (Grant !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold_grant: got %b expected 00", Grant);
    end
    $display("[TB] reset: grant=%b cnt_a=%0d", Grant, PktCount_A);
    do_reset();
  endtask

  task automatic test_single_word;
    A_DataValid = 1'b1; A_LastWord = 1'b1; A_Data = 64'h000441FF00000000; A_DataMod = 3'd4;
    #1;
    n_tests++;
    if (Grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle_grant: got %b expected 00", Grant);
    end
    cyc();
    n_tests++;
    if (Grant !== 2'b01 || InBus_Data !== 64'h000441FF00000000 || InBus_DataMod !== 3'd4 ||
        InBus_LastWord !== 1'b1 || InBus_DataValid !== 1'b1 || A_DataAck !== 1'b1) begin
      n_fail++;
      $display("FAIL single_word_bus: got grant=%b data=%h mod=%0d last=%b vld=%b ack=%b expected 01 000441ff00000000 4 1 1 1",
               Grant, InBus_Data, InBus_DataMod, InBus_LastWord, InBus_DataValid, A_DataAck);
    end
    cyc();
    A_DataValid = 1'b0;
    #1;
    n_tests++;
    if (Grant !== 2'b00 || PktCount_A !== 2'd1) begin
      n_fail++;
      $display("FAIL single_word_done: got grant=%b cnt=%0d expected 00 1", Grant, PktCount_A);
    end
    $display("[TB] single word: grant=%b cnt_a=%0d", Grant, PktCount_A);
  endtask

  task automatic test_back_to_back;
    logic a_idx, b_idx, a_ack, b_ack;
    logic [1:0]  exp_g;
    logic [63:0] exp_d;
    do_reset();
    a_idx = 1'b0;
    b_idx = 1'b0;
    for (int c = 0; c < 12; c++) begin
      A_DataValid = 1'b1; A_LastWord = a_idx; A_Data = a_idx ? A2 : A1;
      A_DataMod = a_idx ? 3'd4 : 3'd0;
      B_DataValid = 1'b1; B_LastWord = b_idx; B_Data = b_idx ? B2 : B1;
      B_DataMod = 3'd0;
      #1;
      // Each packet takes two bus cycles followed by one IDLE cycle; A first.
      if (c % 3 == 0)            exp_g = 2'b00;
      else if ((c / 3) % 2 == 0) exp_g = 2'b01;
      else                       exp_g = 2'b10;
      if (exp_g == 2'b01)      exp_d = (c % 3 == 1) ? A1 : A2;
      else if (exp_g == 2'b10) exp_d = (c % 3 == 1) ? B1 : B2;
      else                     exp_d = 64'h0;
      n_tests++;
      if (Grant !== exp_g || InBus_Data !== exp_d) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: got grant=%b data=%h expected %b %h", c, Grant, InBus_Data, exp_g, exp_d);
      end
      if (exp_g == 2'b01) begin
        n_tests++;
        if (B_DataAck !== 1'b0 || A_DataAck !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_acks_a%0d: got a=%b b=%b expected 1 0", c, A_DataAck, B_DataAck);
        end
      end
      $display("[TB] b2b cycle %0d: grant=%b data=%h", c, Grant, InBus_Data);
      a_ack = A_DataAck;
      b_ack = B_DataAck;
      cyc();
      if (a_ack) a_idx = ~a_idx;
      if (b_ack) b_idx = ~b_idx;
    end
    idle_inputs();
    #1;
    n_tests++;
    if (Grant !== 2'b00 || PktCount_A !== 2'd2 || PktCount_B !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_counts: got grant=%b a=%0d b=%0d expected 00 2 2", Grant, PktCount_A, PktCount_B);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    A_DataValid = 1'b1; A_LastWord = 1'b0; A_Data = A1; A_DataMod = 3'd0;
    cyc();
    cyc();   // word 1 transferred
    A_LastWord = 1'b1; A_Data = A2; A_DataMod = 3'd4;
    InBus_DataAck = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      n_tests++;
      if (InBus_Data !== A2 || A_DataAck !== 1'b0 || PktCount_A !== 2'd0 || Grant !== 2'b01) begin
        n_fail++;
        $display("FAIL stall%0d: got data=%h ack=%b cnt=%0d grant=%b expected %h 0 0 01",
                 s, InBus_Data, A_DataAck, PktCount_A, Grant, A2);
      end
      $display("[TB] stall %0d: data=%h ack=%b", s, InBus_Data, A_DataAck);
      cyc();
    end
    InBus_DataAck = 1'b1;
    #1;
    n_tests++;
    if (A_DataAck !== 1'b1 || PktCount_A !== 2'd0) begin
      n_fail++;
      $display("FAIL stall_release: got ack=%b cnt=%0d expected 1 0", A_DataAck, PktCount_A);
    end
    cyc();
    A_DataValid = 1'b0;
    #1;
    n_tests++;
    if (PktCount_A !== 2'd1 || Grant !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_done: got cnt=%0d grant=%b expected 1 00", PktCount_A, Grant);
    end
  endtask

  task automatic test_truncate;
    do_reset();
    A_DataValid = 1'b1; A_LastWord = 1'b0; A_Data = WBASE; A_DataMod = 3'd0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      A_LastWord = (i == 5);
      A_Data = WBASE + 64'(i);
      #1;
      n_tests++;
      if (i < 4) begin
        if (InBus_DataValid !== 1'b1 || InBus_LastWord !== (i == 3) ||
            InBus_Data !== WBASE + 64'(i) || Trunc_Err !== 1'b0) begin
          n_fail++;
          $display("FAIL trunc_word%0d: got vld=%b last=%b data=%h trunc=%b expected 1 %b %h 0",
                   i, InBus_DataValid, InBus_LastWord, InBus_Data, Trunc_Err, (i == 3), WBASE + 64'(i));
        end
      end else begin
        if (InBus_DataValid !== 1'b0 || A_DataAck !== 1'b1 || Grant !== 2'b01 ||
            Trunc_Err !== (i == 4)) begin
          n_fail++;
          $display("FAIL flush_word%0d: got vld=%b ack=%b grant=%b trunc=%b expected 0 1 01 %b",
                   i, InBus_DataValid, A_DataAck, Grant, Trunc_Err, (i == 4));
        end
      end
      $display("[TB] trunc word %0d: vld=%b last=%b trunc=%b", i, InBus_DataValid, InBus_LastWord, Trunc_Err);
      cyc();
    end
    A_DataValid = 1'b0;
    #1;
    n_tests++;
    if (Grant !== 2'b00 || PktCount_A !== 2'd1 || Trunc_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL trunc_done: got grant=%b cnt=%0d trunc=%b expected 00 1 0", Grant, PktCount_A, Trunc_Err);
    end
    // Exactly MAX_WORDS words ending in LastWord: no truncation.
    A_DataValid = 1'b1; A_LastWord = 1'b0; A_Data = WBASE;
    cyc();
    for (int i = 0; i < 4; i++) begin
      A_LastWord = (i == 3);
      A_Data = WBASE + 64'(i);
      #1;
      n_tests++;
      if (InBus_DataValid !== 1'b1 || Trunc_Err !== 1'b0) begin
        n_fail++;
        $display("FAIL exact_word%0d: got vld=%b trunc=%b expected 1 0", i, InBus_DataValid, Trunc_Err);
      end
      cyc();
    end
    A_DataValid = 1'b0;
    #1;
    n_tests++;
    if (Grant !== 2'b00 || PktCount_A !== 2'd2 || Trunc_Err !== 1'b0) begin
      n_fail++;
      $display("FAIL exact_done: got grant=%b cnt=%0d trunc=%b expected 00 2 0", Grant, PktCount_A, Trunc_Err);
    end
    $display("[TB] exact-length packet: grant=%b cnt_a=%0d", Grant, PktCount_A);
  endtask

  task automatic test_reset_midpacket;
    do_reset();
    A_DataValid = 1'b1; A_LastWord = 1'b1; A_Data = A2;
    cyc();
    cyc();   // A packet done, last served = A
    A_DataValid = 1'b0;
    B_DataValid = 1'b1; B_LastWord = 1'b0; B_Data = B1;
    cyc();
    n_tests++;
    if (Grant !== 2'b10 || PktCount_A !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre: got grant=%b cnt=%0d expected 10 1", Grant, PktCount_A);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (Grant !== 2'b00 || InBus_DataValid !== 1'b0 || B_DataAck !== 1'b0 ||
        PktCount_A !== 2'd0 || PktCount_B !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got grant=%b vld=%b ack=%b cnt=%0d/%0d expected 00 0 0 0/0",
               Grant, InBus_DataValid, B_DataAck, PktCount_A, PktCount_B);
    end
    A_DataValid = 1'b1; A_LastWord = 1'b1; A_Data = A1;
    B_LastWord = 1'b1;
    #2 reset = 1'b1;
    cyc();
    n_tests++;
    if (Grant !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_first_grant: got %b expected 01", Grant);
    end
    $display("[TB] reset mid-packet: grant after release=%b", Grant);
    idle_inputs();
  endtask

  task automatic test_saturate;
    logic [1:0] exp_c;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      A_DataValid = 1'b1; A_LastWord = 1'b1; A_Data = WBASE + 64'(p);
      cyc();
      cyc();
      A_DataValid = 1'b0;
      #1;
      exp_c = (p < 3) ? 2'(p + 1) : 2'd3;
      n_tests++;
      if (PktCount_A !== exp_c) begin
        n_fail++;
        $display("FAIL saturate_pkt%0d: got %0d expected %0d", p, PktCount_A, exp_c);
      end
      $display("[TB] saturate packet %0d: cnt_a=%0d", p, PktCount_A);
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_truncate();
    test_reset_midpacket();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/feed_arbiter.md
Name: feed_arbiter

Overview:
- Packet-level round-robin arbiter that shares the message parser's single 64-bit input bus (InBus_*) between two upstream feed sources, A and B.
- Holds a grant for a whole packet, from the first word through the LastWord transfer; never interleaves words from two packets.
- Enforces a maximum packet length. Over-long packets are cut to the parser and their remainder is drained from the source.
- Sits directly upstream of the parser top-level; per-source packet counters feed status registers.

Parameters:
DATA_W, 64, data bus width
MOD_W, 3, DataMod width (0 = all 8 bytes valid, else count of valid bytes)
MAX_WORDS, 256, maximum words per packet forwarded before truncation (>=2)
CNT_W, 16, width of per-source packet counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
A_DataValid  in  1  source A word valid
A_LastWord  in  1  source A last word of packet
A_Data  in  DATA_W  source A data
A_DataMod  in  MOD_W  source A byte-valid code
A_DataAck  out  1  source A word accepted
B_DataValid, B_LastWord, B_Data, B_DataMod, B_DataAck  (same as A, for source B)
InBus_DataValid  out  1  to parser
InBus_LastWord  out  1  to parser
InBus_Data  out  DATA_W  to parser
InBus_DataMod  out  MOD_W  to parser
InBus_DataAck  in  1  parser accepts the current word
Grant  out  2  one-hot current owner: 01 = A, 10 = B, 00 = none
PktCount_A  out  CNT_W  packets completed from A, saturating
PktCount_B  out  CNT_W  packets completed from B, saturating
Trunc_Err  out  1  one-cycle pulse on truncation

Behaviour:
- Transfer definition: a word moves when the source Valid and the source Ack are both high on a rising edge.
- Reset (reset = 0, asynchronous, effective immediately, including mid-packet):
  - state IDLE, Grant 00, all InBus_* outputs 0, both source Acks 0.
  - word counter 0, PktCount_A/B 0, Trunc_Err 0.
  - last_served = B, so A wins the first tie.
- States: IDLE, GNT_A, GNT_B, FLUSH.
- IDLE:
  - InBus_* outputs driven 0; source Acks 0.
  - Only one source valid: register the grant to it next cycle.
  - Both valid: grant the source that is not last_served.
  - Arbitration latency: one cycle, valid-to-first-word-on-InBus.
- GNT_x:
  - InBus_DataValid/LastWord/Data/DataMod combinationally equal source x's signals.
  - x_DataAck = InBus_DataAck; the other source's Ack = 0.
  - Each transfer increments the word counter, which has width to hold MAX_WORDS.
  - Transfer with LastWord = 1: increment PktCount_x (hold at all-ones), set last_served = x, clear the word counter, go to IDLE.
  - Transfer of word number MAX_WORDS with LastWord = 0:
    - Force InBus_LastWord = 1 on that word only.
    - Pulse Trunc_Err high for the cycle after the transfer.
    - Increment PktCount_x, clear the word counter, go to FLUSH.
- Backpressure: while InBus_DataAck = 0, no Ack to the source and no counter change; source data passes through unchanged.
- FLUSH:
  - InBus_DataValid = 0.
  - x_DataAck = 1, so source words are consumed and dropped.
  - On the source's LastWord transfer: set last_served = x, go to IDLE.
  - Grant stays x.
- Grant is a registered output and is 00 only in IDLE.
- A source dropping Valid mid-packet does not release the grant; the grant waits for LastWord.
- Packet-length rules:
  - A 1-word packet (LastWord on the first word) is legal.
  - A packet of exactly MAX_WORDS words with LastWord on the last word is not truncated.
- No combinational path from InBus_DataAck to any InBus_* output.

Test Plan:
1. After reset, A sends one word 64'h000441FF00000000, Mod = 4, LastWord = 1; parser Ack tied high:
   - Grant = 01 one cycle after A valid.
   - InBus_Data = 64'h000441FF00000000, InBus_DataMod = 4, InBus_LastWord = 1, A_DataAck = 1 in the same cycle.
   - Next cycle: Grant = 00, PktCount_A = 1.
2. A and B both continuously offer 2-word packets (A: 64'h0004415500204401 then 64'hDEADBEEF00000000 with Mod = 4, Last; B: 64'h0014421122334455 then 64'hEEFFEEDD00044101, Last):
   - Grant sequence is A, B, A, B with one IDLE cycle between packets.
   - B_DataAck = 0 throughout every A packet.
3. Parser Ack held low 3 cycles during word 2 of an A packet:
   - InBus_Data holds word 2 and A_DataAck = 0 for those 3 cycles.
   - Transfer completes on the 4th cycle; PktCount_A increments once.
4. MAX_WORDS = 4, A sends a 6-word packet:
   - Word 4 appears on InBus with InBus_LastWord = 1; Trunc_Err pulses for exactly 1 cycle.
   - Words 5-6 are acked to A with InBus_DataValid = 0.
   - Then IDLE; PktCount_A = 1.
5. Reset asserted mid-packet in GNT_B:
   - Grant, InBus_DataValid, B_DataAck and the counters go to 0 immediately, before the next clock.
   - After release with both sources valid, A is granted first.
6. CNT_W = 2, send 5 packets from A: PktCount_A reads 1, 2, 3, 3, 3.
